// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM pipeline stage and its alignment helper.
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } dsize_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  localparam logic [3:0] BE_BYTE = 4'b1000;
  localparam logic [3:0] BE_HALF = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Half needs an even offset; word (size 2 or 3) needs offset 0.
  function automatic logic isMisaligned(input logic [1:0] dSize, input logic [1:0] off);
    return (dSize == HALF && off[0]) || (dSize[1] && off != 2'b00);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational big-endian lane steering: store byte enables/data replication and load shift.
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  dSize,
  input  logic        isStore,
  input  logic [1:0]  off,
  input  logic [31:0] storeData,
  input  logic [1:0]  rdOff,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdAligned
);

  always_comb begin
    be    = BE_WORD;
    wdata = storeData;
    if (isStore) begin
      case (dSize)
        BYTE: begin
          be    = BE_BYTE >> off;
          wdata = {4{storeData[7:0]}};
        end
        HALF: begin
          be    = BE_HALF >> {off[1], 1'b0};
          wdata = {2{storeData[15:0]}};
        end
        default: begin
          be    = BE_WORD;
          wdata = storeData;
        end
      endcase
    end
  end

  // Addressed byte/half lands in the top bits for WB's zero-extending resize.
  assign rdAligned = rdata << {rdOff, 3'b000};

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory accesses over req/ack, stalls upstream, registers MEM/WB.
// Optional: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of force-aligning.
module mem_stage
  import mem_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          memRd,
  input  logic          memWr,
  input  logic          link,
  input  logic          fp,
  input  logic          regWr,
  input  logic [1:0]    dSize,
  input  logic [4:0]    rd,
  input  logic [31:0]   aluRes,
  input  logic [31:0]   storeData,
  input  logic [31:0]   reg31Val,
  output logic          stall,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [3:0]    dmem_be,
  output logic [31:0]   dmem_wdata,
  input  logic          dmem_ack,
  input  logic [31:0]   dmem_rdata,
  output logic          wb_valid,
  output logic          wb_memRd,
  output logic          wb_link,
  output logic          wb_fp,
  output logic          wb_regWr,
  output logic [1:0]    wb_dSize,
  output logic [4:0]    wb_rd,
  output logic [31:0]   wb_memRdData,
  output logic [31:0]   wb_aluRes,
  output logic [31:0]   wb_reg31Val
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic          trap_misalign
`endif
);

  mem_state_t  state;
  logic        misal;
  logic        accept;
  logic [3:0]  reqBe;
  logic [31:0] reqWdata;
  logic [31:0] rdAligned;

  // Instruction held while the access is outstanding.
  logic [1:0]  pOff;
  logic [1:0]  pDSize;
  logic        pMemRd, pLink, pFp, pRegWr;
  logic [4:0]  pRd;
  logic [31:0] pAluRes, pReg31Val;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misal = isMisaligned(dSize, aluRes[1:0]);
`else
  assign misal = 1'b0;
`endif

  assign accept = (state == IDLE) && in_valid && (memRd || memWr) && !misal;
  assign stall  = accept || (state == BUSY && !dmem_ack);

  mem_align uAlign (
    .dSize     (dSize),
    .isStore   (memWr & ~memRd),
    .off       (aluRes[1:0]),
    .storeData (storeData),
    .rdOff     (pOff),
    .rdata     (dmem_rdata),
    .be        (reqBe),
    .wdata     (reqWdata),
    .rdAligned (rdAligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= 4'b0000;
      dmem_wdata   <= 32'd0;
      wb_valid     <= 1'b0;
      wb_memRd     <= 1'b0;
      wb_link      <= 1'b0;
      wb_fp        <= 1'b0;
      wb_regWr     <= 1'b0;
      wb_dSize     <= 2'd0;
      wb_rd        <= 5'd0;
      wb_memRdData <= 32'd0;
      wb_aluRes    <= 32'd0;
      wb_reg31Val  <= 32'd0;
      pOff         <= 2'd0;
      pDSize       <= 2'd0;
      pMemRd       <= 1'b0;
      pLink        <= 1'b0;
      pFp          <= 1'b0;
      pRegWr       <= 1'b0;
      pRd          <= 5'd0;
      pAluRes      <= 32'd0;
      pReg31Val    <= 32'd0;
`ifdef MEM_MISALIGN_TRAP_EN
      trap_misalign <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      trap_misalign <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= BUSY;
            dmem_req   <= 1'b1;
            dmem_we    <= memWr & ~memRd;
            dmem_addr  <= {aluRes[AW-1:2], 2'b00};
            dmem_be    <= reqBe;
            dmem_wdata <= reqWdata;
            pOff       <= aluRes[1:0];
            pDSize     <= dSize;
            pMemRd     <= memRd;
            pLink      <= link;
            pFp        <= fp;
            pRegWr     <= regWr;
            pRd        <= rd;
            pAluRes    <= aluRes;
            pReg31Val  <= reg31Val;
          end else if (in_valid) begin
            // Non-memory op, or a trapped misaligned access that must not write the register file.
            wb_valid     <= 1'b1;
            wb_memRd     <= memRd;
            wb_link      <= link;
            wb_fp        <= fp;
            wb_regWr     <= regWr & ~misal;
            wb_dSize     <= dSize;
            wb_rd        <= rd;
            wb_memRdData <= 32'd0;
            wb_aluRes    <= aluRes;
            wb_reg31Val  <= reg31Val;
`ifdef MEM_MISALIGN_TRAP_EN
            trap_misalign <= misal;
`endif
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            state        <= IDLE;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            wb_valid     <= 1'b1;
            wb_memRd     <= pMemRd;
            wb_link      <= pLink;
            wb_fp        <= pFp;
            wb_regWr     <= pRegWr;
            wb_dSize     <= pDSize;
            wb_rd        <= pRd;
            wb_memRdData <= pMemRd ? rdAligned : 32'd0;
            wb_aluRes    <= pAluRes;
            wb_reg31Val  <= pReg31Val;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
